// File: rtl/sweep_sequencer.sv
// Triangle-sweep controller for an external WIDTH-bit up/down counter.
// Loads lo, counts up to hi, dwells PAUSE cycles, counts down to lo, and
// repeats reps times before pulsing done. Strobes are Moore-decoded from
// the registered state; done/err are registered one-cycle pulses.
module sweep_sequencer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned PAUSE = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [3:0]       reps,
  input  logic [WIDTH-1:0] cuenta,
  output logic             load,
  output logic             ce,
  output logic             dir,
  output logic [WIDTH-1:0] datain,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [3:0]       rep_left
);

  typedef enum logic [2:0] {IDLE, LOAD, UP, DWELL, DOWN, DONE} state_t;

  localparam int unsigned DW = (PAUSE > 2) ? $clog2(PAUSE) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'((PAUSE > 0) ? PAUSE - 1 : 0);

  state_t           state, state_nx;
  logic [WIDTH-1:0] lo_q, hi_q;
  logic [DW-1:0]    dwell_cnt;
  logic             start_ok;
  logic             up_last;
  logic             down_last;
  logic             dwell_last;
  logic [3:0]       rep_dec;

  assign start_ok   = (lo < hi) && (reps != '0);
  // Leave one count early: the counter lands on the bound on the same edge.
  assign up_last    = (cuenta == hi_q - WIDTH'(1));
  assign down_last  = (cuenta == lo_q + WIDTH'(1));
  assign dwell_last = (dwell_cnt == DWELL_LAST);
  assign rep_dec    = rep_left - 4'd1;

  // Next-state decode; abort overrides every non-IDLE transition.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (!abort && start && start_ok) state_nx = LOAD;
      LOAD:  state_nx = UP;
      UP:    if (up_last) state_nx = (PAUSE > 0) ? DWELL : DOWN;
      DWELL: if (dwell_last) state_nx = DOWN;
      DOWN:  if (down_last) state_nx = (rep_dec == '0) ? DONE : UP;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (abort && state != IDLE) state_nx = IDLE;
  end

  // State, captured bounds, repetition and dwell counters, and pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      lo_q      <= '0;
      hi_q      <= '0;
      rep_left  <= '0;
      dwell_cnt <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nx;
      done      <= (state == DOWN) && (state_nx == DONE);
      err       <= (state == IDLE) && start && !abort && !start_ok;
      dwell_cnt <= (state == DWELL) ? dwell_cnt + DW'(1) : '0;
      if (state == IDLE && state_nx == LOAD) begin
        lo_q     <= lo;
        hi_q     <= hi;
        rep_left <= reps;
      end else if (abort && state != IDLE) begin
        rep_left <= '0;
      end else if (state == DOWN && down_last) begin
        rep_left <= rep_dec;
      end
    end
  end

  // Moore output decode from the registered state.
  always_comb begin
    load   = (state == LOAD);
    ce     = (state == UP) || (state == DOWN);
    dir    = (state == DOWN);
    busy   = (state == LOAD) || (state == UP) || (state == DWELL) || (state == DOWN);
    datain = (state == IDLE) ? '0 : lo_q;
  end

endmodule

// File: tb/tb_sweep_sequencer.sv
// Bench for sweep_sequencer: three instances (PAUSE = 2, 0, 1), each driving
// its own behavioural up/down counter; expected per-cycle outputs are queued
// at start and compared as the sweep runs.
module tb_sweep_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       abort_s = 1'b0;
  logic [3:0] lo_s = '0, hi_s = '0, reps_s = '0;
  logic       start_v [3];
  logic [3:0] cuenta_v [3];
  logic [3:0] datain_v [3];
  logic [3:0] rep_left_v [3];
  logic       load_v [3], ce_v [3], dir_v [3], busy_v [3], done_v [3], err_v [3];

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic       chk_c;
    logic [3:0] c;
    logic [3:0] rl;
    logic [3:0] dat;
    logic [5:0] fl; // {load, ce, dir, busy, done, err}
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned PV = (g == 0) ? 2 : ((g == 1) ? 0 : 1);
    logic [3:0] cnt;

    sweep_sequencer #(.WIDTH(4), .PAUSE(PV)) u_dut (
      .clk(clk), .reset(reset), .start(start_v[g]), .abort(abort_s),
      .lo(lo_s), .hi(hi_s), .reps(reps_s), .cuenta(cuenta_v[g]),
      .load(load_v[g]), .ce(ce_v[g]), .dir(dir_v[g]), .datain(datain_v[g]),
      .busy(busy_v[g]), .done(done_v[g]), .err(err_v[g]), .rep_left(rep_left_v[g])
    );

    // External counter: load over ce, +1/-1 per dir.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) cnt <= '0;
      else if (load_v[g]) cnt <= datain_v[g];
      else if (ce_v[g]) cnt <= dir_v[g] ? cnt - 4'd1 : cnt + 4'd1;
    end
    assign cuenta_v[g] = cnt;
  end

  function automatic int pause_of(input int sel);
    return (sel == 0) ? 2 : ((sel == 1) ? 0 : 1);
  endfunction

  function automatic logic [5:0] flags_of(input int sel);
    return {load_v[sel], ce_v[sel], dir_v[sel], busy_v[sel], done_v[sel], err_v[sel]};
  endfunction

  task automatic push(input logic chk, input logic [3:0] c, input logic [3:0] rl,
                      input logic [3:0] dat, input logic [5:0] fl);
    exp_t e;
    e.chk_c = chk; e.c = c; e.rl = rl; e.dat = dat; e.fl = fl;
    exp_q.push_back(e);
  endtask

  // Drives a one-cycle start; returns at the sample point after the start edge.
  task automatic pulse_start(input int sel, input logic [3:0] l, input logic [3:0] h,
                             input logic [3:0] r);
    @(negedge clk);
    lo_s = l; hi_s = h; reps_s = r; start_v[sel] = 1'b1;
    @(negedge clk);
    start_v[sel] = 1'b0;
  endtask

  task automatic sweep(input int sel, input logic [3:0] l, input logic [3:0] h,
                       input logic [3:0] r, input bit mid_change, input string tag);
    exp_t e;
    int p, k, done_k, total;
    logic [3:0] rl;
    p = pause_of(sel);
    push(1'b0, 4'd0, r, l, 6'b100100);
    for (int rep = 0; rep < int'(r); rep++) begin
      rl = r - 4'(rep);
      for (int v = int'(l); v < int'(h); v++) push(1'b1, 4'(v), rl, l, 6'b010100);
      for (int i = 0; i < p; i++) push(1'b1, h, rl, l, 6'b000100);
      for (int v = int'(h); v > int'(l); v--) push(1'b1, 4'(v), rl, l, 6'b011100);
    end
    push(1'b1, l, 4'd0, l, 6'b000010);
    push(1'b1, l, 4'd0, 4'd0, 6'b000000);

    pulse_start(sel, l, h, r);
    k = 0;
    done_k = -1;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (flags_of(sel) !== e.fl) begin
        n_fail++;
        $display("FAIL %s flags k=%0d got %b want %b", tag, k, flags_of(sel), e.fl);
      end
      n_checks++;
      if (rep_left_v[sel] !== e.rl) begin
        n_fail++;
        $display("FAIL %s rep_left k=%0d got %0d want %0d", tag, k, rep_left_v[sel], e.rl);
      end
      n_checks++;
      if (datain_v[sel] !== e.dat) begin
        n_fail++;
        $display("FAIL %s datain k=%0d got %0d want %0d", tag, k, datain_v[sel], e.dat);
      end
      if (e.chk_c) begin
        n_checks++;
        if (cuenta_v[sel] !== e.c) begin
          n_fail++;
          $display("FAIL %s cuenta k=%0d got %0d want %0d", tag, k, cuenta_v[sel], e.c);
        end
        n_checks++;
        if (cuenta_v[sel] < l || cuenta_v[sel] > h) begin
          n_fail++;
          $display("FAIL %s range k=%0d got %0d want %0d..%0d", tag, k, cuenta_v[sel], l, h);
        end
      end
      if (done_v[sel] === 1'b1 && done_k < 0) done_k = k;
      if (mid_change && k == 2) begin
        lo_s = 4'd0; hi_s = 4'd15; reps_s = 4'd9;
      end
      k++;
      @(negedge clk);
    end
    total = 2 + int'(r) * (2 * (int'(h) - int'(l)) + p);
    n_checks++;
    if (done_k != total - 1) begin
      n_fail++;
      $display("FAIL %s done_timing got %0d want %0d", tag, done_k, total - 1);
    end
  endtask

  task automatic test_reset();
    #3;
    for (int s = 0; s < 3; s++) begin
      n_checks++;
      if ({flags_of(s), datain_v[s], rep_left_v[s]} !== 14'd0) begin
        n_fail++;
        $display("FAIL reset_outputs inst=%0d got %b want 0", s,
                 {flags_of(s), datain_v[s], rep_left_v[s]});
      end
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_triangle();
    sweep(0, 4'd3, 4'd6, 4'd2, 1'b0, "triangle");
  endtask

  task automatic test_reject(input logic [3:0] l, input logic [3:0] h, input logic [3:0] r,
                             input string tag);
    pulse_start(0, l, h, r);
    n_checks++;
    if (flags_of(0) !== 6'b000001) begin
      n_fail++;
      $display("FAIL %s err_pulse got %b want 000001", tag, flags_of(0));
    end
    @(negedge clk);
    n_checks++;
    if (flags_of(0) !== 6'b000000) begin
      n_fail++;
      $display("FAIL %s after_err got %b want 000000", tag, flags_of(0));
    end
  endtask

  task automatic test_full_range();
    sweep(1, 4'd0, 4'd15, 4'd1, 1'b0, "full_range");
  endtask

  task automatic test_abort();
    int i;
    pulse_start(0, 4'd2, 4'd10, 4'd3);
    i = 0;
    while (!(cuenta_v[0] == 4'd7 && ce_v[0] && !dir_v[0]) && i < 100) begin
      @(negedge clk);
      i++;
    end
    n_checks++;
    if (i >= 100) begin
      n_fail++;
      $display("FAIL abort_wait got timeout want cuenta 7 in UP");
    end
    abort_s = 1'b1;
    @(negedge clk);
    abort_s = 1'b0;
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if ({flags_of(0), rep_left_v[0], cuenta_v[0]} !== {6'b000000, 4'd0, 4'd8}) begin
        n_fail++;
        $display("FAIL abort_hold c=%0d got %b/%0d/%0d want 000000/0/8", c,
                 flags_of(0), rep_left_v[0], cuenta_v[0]);
      end
      @(negedge clk);
    end
    // Abort and a valid start together in IDLE: start ignored.
    lo_s = 4'd1; hi_s = 4'd5; reps_s = 4'd1; start_v[0] = 1'b1; abort_s = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0; abort_s = 1'b0;
    n_checks++;
    if (flags_of(0) !== 6'b000000) begin
      n_fail++;
      $display("FAIL abort_start got %b want 000000", flags_of(0));
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    int i;
    pulse_start(0, 4'd2, 4'd6, 4'd1);
    i = 0;
    while (!(dir_v[0] && ce_v[0]) && i < 100) begin
      @(negedge clk);
      i++;
    end
    n_checks++;
    if (i >= 100) begin
      n_fail++;
      $display("FAIL areset_wait got timeout want DOWN");
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({flags_of(0), datain_v[0], rep_left_v[0]} !== 14'd0) begin
      n_fail++;
      $display("FAIL areset_outputs got %b want 0", {flags_of(0), datain_v[0], rep_left_v[0]});
    end
    @(negedge clk);
    reset = 1'b1;
    sweep(0, 4'd1, 4'd3, 4'd1, 1'b0, "after_reset");
  endtask

  task automatic test_narrow_window();
    sweep(2, 4'd4, 4'd5, 4'd2, 1'b1, "narrow");
  endtask

  initial begin
    for (int s = 0; s < 3; s++) start_v[s] = 1'b0;
    test_reset();
    test_triangle();
    test_reject(4'd7, 4'd7, 4'd2, "reject_eq");
    test_reject(4'd2, 4'd9, 4'd0, "reject_reps0");
    test_full_range();
    test_abort();
    test_async_reset();
    test_narrow_window();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/sweep_sequencer.md
Name: sweep_sequencer

Overview:
- Controller that drives the load/ce/dir/datain inputs of the team's WIDTH-bit up/down counter (the P3-style counter) and monitors its cuenta output.
- Runs programmed triangle sweeps: load lo, count up to hi, dwell, count down to lo, repeated reps times, then signals done.
- Sits between the control logic (start/abort) and the counter instance; the counter itself is external.

Parameters:
WIDTH, 4, bit width of the counter value, lo, hi and datain
PAUSE, 2, dwell cycles at hi with ce=0 (0 = no dwell state)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  request a sweep; sampled only in IDLE
abort  input  1  stop the sweep; return to IDLE
lo  input  WIDTH  lower sweep bound
hi  input  WIDTH  upper sweep bound
reps  input  4  number of up/down cycles
cuenta  input  WIDTH  current counter value, fed back from the counter
load  output  1  counter load strobe
ce  output  1  counter count enable
dir  output  1  counter direction: 0 = up, 1 = down
datain  output  WIDTH  counter load value
busy  output  1  sweep in progress
done  output  1  one-cycle pulse at sweep completion
err  output  1  one-cycle pulse when start is rejected
rep_left  output  4  remaining repetitions

Behaviour:
- Counter contract: synchronous; load has priority over ce; when ce=1 the counter applies +1/-1 per dir at each clk edge.
- reset low (async): state=IDLE; load=ce=dir=busy=done=err=0; datain=0; rep_left=0; lo/hi/reps capture registers cleared.
- States: IDLE, LOAD, UP, DWELL, DOWN, DONE. State, captures and counters are registered. Outputs are decoded from the registered state (Moore), except done/err, which are registered pulses.
- IDLE: all strobes 0, busy=0.
  - start=1 with lo<hi and reps!=0: capture lo_q/hi_q/reps_q; rep_left<=reps; go to LOAD.
  - start=1 with lo>=hi or reps==0: err=1 for one cycle; stay in IDLE.
- LOAD (1 cycle): load=1, datain=lo_q, busy=1; next state UP.
- UP: ce=1, dir=0. Leave when cuenta==hi_q-1, so the counter reaches hi_q on the same edge the state changes. Next state is DWELL if PAUSE>0, else DOWN.
  - If hi_q==lo_q+1, UP lasts exactly 1 cycle.
- DWELL: ce=0; internal counter runs PAUSE cycles; then DOWN.
- DOWN: ce=1, dir=1. Leave when cuenta==lo_q+1 and decrement rep_left.
  - rep_left after decrement !=0: go to UP.
  - rep_left after decrement ==0: go to DONE.
- DONE (1 cycle): ce=0, done=1, busy=0; next state IDLE.
- busy=1 in LOAD, UP, DWELL and DOWN.
- datain=lo_q in every non-IDLE state.
- lo/hi/reps changes after start are ignored until the next accepted start.
- abort=1 in any non-IDLE state: next state IDLE, rep_left<=0, no done pulse. In the abort cycle itself, outputs still follow the current state. The counter keeps its last value.
- abort and start in the same IDLE cycle: abort wins; start is ignored.
- start while busy: ignored.
- Arithmetic: hi_q-1 and lo_q+1 are WIDTH-bit. No wrap is possible, because lo<hi is enforced at start.
- Total cycles from accepted start to DONE inclusive: 1 + reps*(2*(hi-lo)+PAUSE) + 1.

Test Plan:
1. Reset, then lo=3, hi=6, reps=2, PAUSE=2, one-cycle start, with the P3 counter attached:
   - cuenta sequence 3,4,5,6,6,6,5,4,3,4,5,6,6,6,5,4,3.
   - done pulses exactly 18 cycles after the start edge.
   - cuenta never leaves 3..6.
   - rep_left goes 2→1→0.
2. lo=7, hi=7, start: err=1 for 1 cycle, busy stays 0, load never asserted. Repeat with lo=2, hi=9, reps=0: same response.
3. lo=0, hi=15, reps=1, PAUSE=0: cuenta 0→15→0 with no dwell, no overshoot past 15 or below 0; done after 32 cycles.
4. lo=2, hi=10, reps=3, abort asserted while cuenta==7 in UP:
   - ce=0 and busy=0 from the next cycle.
   - rep_left=0, no done pulse, cuenta holds 8.
5. reset driven low mid-DOWN (asynchronously, between edges): all outputs go to 0 immediately. After release, a new start with lo=1, hi=3, reps=1 completes normally.
6. lo=4, hi=5, reps=2, PAUSE=1: UP and DOWN each last 1 cycle; cuenta 4,5,5,4,5,5,4; change lo/hi mid-run and confirm no effect.
